// File: rtl/led_mode_sequencer.sv
// LED mode sequencer: the center button cycles SWITCH/COUNT/SHIFT/BLINK and the
// up button pauses the pattern prescaler. All outputs come straight from flops.
module led_mode_sequencer #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       button_center_db,
  input  logic       button_up_db,
  input  logic [7:0] sw,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    MODE_SWITCH = 2'b00,
    MODE_COUNT  = 2'b01,
    MODE_SHIFT  = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  mode_e            mode_q, mode_d, mode_next;
  logic             paused_q, paused_d;
  logic [7:0]       pattern_q, pattern_d;
  logic [7:0]       led_q, led_d;
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             center_hist_q, center_hist_d;
  logic             up_hist_q, up_hist_d;
  logic             center_press, up_press, tick;

  // Button history tracks the level even in reset, so a button held across
  // reset release is seen as already pressed and yields no edge.
  always_ff @(posedge clk) begin
    center_hist_q <= center_hist_d;
    up_hist_q     <= up_hist_d;
    if (rst) begin
      mode_q    <= MODE_SWITCH;
      paused_q  <= 1'b0;
      pattern_q <= 8'h00;
      presc_q   <= '0;
      led_q     <= 8'h00;
    end else begin
      mode_q    <= mode_d;
      paused_q  <= paused_d;
      pattern_q <= pattern_d;
      presc_q   <= presc_d;
      led_q     <= led_d;
    end
  end

  always_comb begin
    center_hist_d = button_center_db;
    up_hist_d     = button_up_db;
    center_press  = button_center_db & ~center_hist_q;
    up_press      = button_up_db & ~up_hist_q;
    tick          = ~paused_q && (presc_q == CNT_MAX);
    mode_next     = mode_e'(mode_q + 2'd1);

    mode_d    = mode_q;
    paused_d  = paused_q ^ up_press;
    pattern_d = pattern_q;
    presc_d   = presc_q;

    if (center_press) begin
      // A mode change discards any coincident tick and restarts the prescaler.
      mode_d  = mode_next;
      presc_d = '0;
      case (mode_next)
        MODE_COUNT: pattern_d = 8'h00;
        MODE_SHIFT: pattern_d = 8'h01;
        MODE_BLINK: pattern_d = 8'hFF;
        default:    pattern_d = 8'h00;
      endcase
    end else begin
      if (!paused_q) begin
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
      end
      if (tick) begin
        case (mode_q)
          MODE_COUNT: pattern_d = pattern_q + 8'd1;
          MODE_SHIFT: pattern_d = {pattern_q[6:0], pattern_q[7]};
          MODE_BLINK: pattern_d = ~pattern_q;
          default:    pattern_d = pattern_q;
        endcase
      end
    end

    // led mirrors the pattern register exactly outside SWITCH mode.
    led_d = (mode_d == MODE_SWITCH) ? sw : pattern_d;
  end

  assign led    = led_q;
  assign mode   = mode_q;
  assign paused = paused_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with TICK_DIV=4: per-cycle vector table
// for reset/switch/pause/reset-with-held-button, loops for the long tick sequences.
module tb_led_mode_sequencer;

  logic       clk;
  logic       rst;
  logic       button_center_db;
  logic       button_up_db;
  logic [7:0] sw;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;

  int checks;
  int failures;

  led_mode_sequencer #(.TICK_DIV(4)) dut (
    .clk              (clk),
    .rst              (rst),
    .button_center_db (button_center_db),
    .button_up_db     (button_up_db),
    .sw               (sw),
    .led              (led),
    .mode             (mode),
    .paused           (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       c;
    logic       u;
    logic [7:0] s;
    logic [7:0] e_led;
    logic [1:0] e_mode;
    logic       e_paused;
  } vec_t;

  localparam int NV   = 37;
  localparam int PART = 13;
  vec_t vecs [NV];

  task automatic set_vec(input int i, input logic r, input logic c, input logic u,
                         input logic [7:0] s, input logic [7:0] el,
                         input logic [1:0] em, input logic ep);
    vecs[i].r = r; vecs[i].c = c; vecs[i].u = u; vecs[i].s = s;
    vecs[i].e_led = el; vecs[i].e_mode = em; vecs[i].e_paused = ep;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
  task automatic step(input logic r, input logic c, input logic u, input logic [7:0] s);
    rst = r; button_center_db = c; button_up_db = u; sw = s;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] el,
                       input logic [1:0] em, input logic ep);
    checks++;
    if (led !== el || mode !== em || paused !== ep) begin
      failures++;
      $display("FAIL %s: got led=%h mode=%b paused=%b, want led=%h mode=%b paused=%b",
               name, led, mode, paused, el, em, ep);
    end
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      step(vecs[i].r, vecs[i].c, vecs[i].u, vecs[i].s);
      check($sformatf("vec%0d", i), vecs[i].e_led, vecs[i].e_mode, vecs[i].e_paused);
      $display("vec %0d rst=%b c=%b u=%b sw=%h -> led=%h mode=%b paused=%b",
               i, vecs[i].r, vecs[i].c, vecs[i].u, vecs[i].s, led, mode, paused);
    end
  endtask

  initial begin
    logic [7:0] exp_led;
    checks = 0;
    failures = 0;
    rst = 1'b1; button_center_db = 1'b0; button_up_db = 1'b0; sw = 8'h00;

    // Reset with center held through release, SWITCH follow, first COUNT ticks.
    set_vec(0,  1, 0, 0, 8'hA5, 8'h00, 2'b00, 0);
    set_vec(1,  1, 1, 0, 8'hA5, 8'h00, 2'b00, 0);
    set_vec(2,  0, 1, 0, 8'hA5, 8'hA5, 2'b00, 0);
    set_vec(3,  0, 0, 0, 8'h3C, 8'h3C, 2'b00, 0);
    set_vec(4,  0, 1, 0, 8'h3C, 8'h00, 2'b01, 0);
    set_vec(5,  0, 1, 0, 8'h55, 8'h00, 2'b01, 0);
    set_vec(6,  0, 0, 0, 8'h55, 8'h00, 2'b01, 0);
    set_vec(7,  0, 0, 0, 8'h55, 8'h00, 2'b01, 0);
    set_vec(8,  0, 0, 0, 8'h55, 8'h01, 2'b01, 0);
    set_vec(9,  0, 0, 0, 8'h55, 8'h01, 2'b01, 0);
    set_vec(10, 0, 0, 0, 8'h55, 8'h01, 2'b01, 0);
    set_vec(11, 0, 0, 0, 8'h55, 8'h01, 2'b01, 0);
    set_vec(12, 0, 0, 0, 8'h55, 8'h02, 2'b01, 0);
    // Joint center+up press, pause held across modes, reset in paused BLINK.
    set_vec(13, 0, 1, 1, 8'h5A, 8'h5A, 2'b00, 1);
    set_vec(14, 0, 0, 0, 8'hC3, 8'hC3, 2'b00, 1);
    set_vec(15, 0, 1, 0, 8'hC3, 8'h00, 2'b01, 1);
    set_vec(16, 0, 0, 0, 8'hC3, 8'h00, 2'b01, 1);
    set_vec(17, 0, 0, 0, 8'hC3, 8'h00, 2'b01, 1);
    set_vec(18, 0, 0, 0, 8'hC3, 8'h00, 2'b01, 1);
    set_vec(19, 0, 0, 0, 8'hC3, 8'h00, 2'b01, 1);
    set_vec(20, 0, 1, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(21, 0, 0, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(22, 0, 0, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(23, 0, 0, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(24, 0, 0, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(25, 0, 0, 0, 8'hC3, 8'h01, 2'b10, 1);
    set_vec(26, 0, 1, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(27, 0, 0, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(28, 0, 0, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(29, 0, 0, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(30, 0, 0, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(31, 0, 0, 0, 8'hC3, 8'hFF, 2'b11, 1);
    set_vec(32, 1, 1, 0, 8'hC3, 8'h00, 2'b00, 0);
    set_vec(33, 0, 1, 0, 8'hC3, 8'hC3, 2'b00, 0);
    set_vec(34, 0, 1, 0, 8'hC3, 8'hC3, 2'b00, 0);
    set_vec(35, 0, 0, 0, 8'h11, 8'h11, 2'b00, 0);
    set_vec(36, 0, 0, 0, 8'h11, 8'h11, 2'b00, 0);

    run_table(0, PART);

    // COUNT wraps to 0x00 after 256 ticks (1024 cycles after entry).
    for (int k = 0; k < 1016; k++) step(0, 0, 0, 8'h55);
    check("count_wrap", 8'h00, 2'b01, 0);
    $display("count wrap at 1024 cycles: led=%h", led);

    for (int k = 1; k <= 12; k++) begin
      step(0, 0, 0, 8'h55);
      exp_led = 8'(k / 4);
      check($sformatf("count_%0d", k), exp_led, 2'b01, 0);
    end

    // Pause with the prescaler frozen at 2; resume must increment 2 cycles later.
    step(0, 0, 0, 8'h55);
    check("pre_pause", 8'h03, 2'b01, 0);
    step(0, 0, 1, 8'h55);
    check("pause_on", 8'h03, 2'b01, 1);
    for (int k = 0; k < 100; k++) begin
      step(0, 0, 0, 8'h55);
      check("paused_hold", 8'h03, 2'b01, 1);
    end
    step(0, 0, 1, 8'h55);
    check("pause_off", 8'h03, 2'b01, 0);
    step(0, 0, 0, 8'h55);
    check("resume_1", 8'h03, 2'b01, 0);
    step(0, 0, 0, 8'h55);
    check("resume_2", 8'h04, 2'b01, 0);
    $display("pause/resume sequence: led=%h", led);

    // Center press in the tick cycle: SHIFT entry value, no increment.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 8'h55);
      check("pre_tick", 8'h04, 2'b01, 0);
    end
    step(0, 1, 0, 8'h55);
    check("press_vs_tick", 8'h01, 2'b10, 0);

    // SHIFT rotates through 0x80 back to 0x01 over 8 ticks.
    for (int k = 1; k <= 32; k++) begin
      step(0, 0, 0, 8'h55);
      exp_led = 8'h01 << ((k / 4) % 8);
      check($sformatf("shift_%0d", k), exp_led, 2'b10, 0);
    end
    $display("shift full rotation: led=%h", led);

    // Hold center 20 cycles: one advance into BLINK, inversions continue.
    for (int k = 1; k <= 21; k++) begin
      step(0, (k <= 20), 0, 8'h55);
      exp_led = (((k - 1) / 4) % 2 == 1) ? 8'h00 : 8'hFF;
      check($sformatf("blink_hold_%0d", k), exp_led, 2'b11, 0);
    end
    $display("held center, mode=%b led=%h", mode, led);

    run_table(PART, NV);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
LED_MODE_SEQUENCER -- requirements
Module: led_mode_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 25000000, clock cycles per pattern tick; legal range 2..2^26.
REQ-002 Port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port button_center_db  input  1  debounced center button level; a rising edge advances the mode.
REQ-005 Port button_up_db  input  1  debounced up button level; a rising edge toggles pause.
REQ-006 Port sw  input  8  slide switch levels.
REQ-007 Port led  output  8  registered LED drive.
REQ-008 Port mode  output  2  registered current mode: 00 SWITCH, 01 COUNT, 10 SHIFT, 11 BLINK.
REQ-009 Port paused  output  1  registered pause flag.

Function
REQ-010 Press detect: each button SHALL have a one-flop history; press = level & ~history, a one-cycle pulse; history SHALL load the button level every cycle, including during reset.
REQ-011 Held button SHALL produce exactly one press; a button held through reset release SHALL produce no press.
REQ-012 Mode FSM: a center press SHALL advance mode SWITCH->COUNT->SHIFT->BLINK->SWITCH on the next edge, regardless of paused.
REQ-013 Pattern register (8 bits) SHALL load on mode entry, on the same edge the mode updates: COUNT 0x00, SHIFT 0x01, BLINK 0xFF, SWITCH 0x00.
REQ-014 Prescaler: counter 0..TICK_DIV-1; tick = one-cycle pulse when counter == TICK_DIV-1, then counter wraps to 0.
REQ-015 Prescaler SHALL hold its value while paused=1 and produce no tick.
REQ-016 Prescaler SHALL clear to 0 on a mode change, so the first tick in a new mode occurs TICK_DIV cycles after entry.
REQ-017 On tick in COUNT: pattern +1 modulo 256 (0xFF->0x00).
REQ-018 On tick in SHIFT: rotate left by 1 (0x80->0x01).
REQ-019 On tick in BLINK: pattern inverted (0xFF<->0x00).
REQ-020 In SWITCH, led SHALL equal sw delayed by one clock, independent of ticks and paused.
REQ-021 In COUNT/SHIFT/BLINK, led SHALL equal the pattern register (same register, no extra delay).
REQ-022 A center press and a tick in the same cycle: press wins; the tick is discarded and the new mode's entry value loads.
REQ-023 An up press SHALL toggle paused on the next edge; simultaneous up and center presses SHALL both take effect on the same edge.
REQ-024 Pause SHALL persist across mode changes.
REQ-025 Multi-bit state SHALL never take values outside the listed encodings; all four mode codes are legal.

Reset
REQ-026 While rst=1 at a clock edge: mode=00, paused=0, pattern=0x00, prescaler=0, led=0x00.
REQ-027 rst SHALL override all presses and ticks on the same edge.
REQ-028 Reset asserted mid-operation in any mode SHALL return to the REQ-026 state in one cycle.
REQ-029 First led update after reset release SHALL follow SWITCH behaviour (led = sw one cycle later).

Verification (TICK_DIV=4)
REQ-030 Reset release, sw=0xA5 -> mode=00, led=0x00 during reset, led=0xA5 one cycle after release; sw=0x3C -> led=0x3C next cycle.
REQ-031 One center press -> mode=01, led=0x00; after 4, 8, 1024 cycles led=0x01, 0x02, 0x00 (wrap).
REQ-032 Two presses -> mode=10, led=0x01; 8 ticks later led back to 0x01 via 0x80; hold center for 20 cycles -> mode advances once only.
REQ-033 In COUNT at led=0x03, up press -> paused=1, led frozen for 100 cycles; up press again -> next increment exactly 4 cycles minus frozen prescaler value later.
REQ-034 Center press aligned with tick cycle in COUNT -> mode=10, led=0x01, no increment observed; center and up pressed together -> mode advances and paused toggles on the same edge.
REQ-035 In BLINK with paused=1, assert rst for one cycle -> mode=00, paused=0, led=0x00; button held during reset -> no mode change after release.
